// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, fetch FSM encoding and PC alignment helper
//   XLEN         datapath / address width
//   INSTR_BYTES  PC increment per fetched word
//   fetch_state_e RUN issues fetches, MISS waits out an l1i refill
package instruction_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_MISS = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// instruction_fetch_buffer: synchronous FIFO with push/pop/flush, flush has priority
//   clock, reset  posedge clock, async active-high reset (contents cleared to 0)
//   push, din     write din when not full, or when full and popping this cycle
//   pop           drop head (ignored when empty or flushing)
//   flush         empty the buffer; suppresses same-cycle push and pop
//   dout          head entry (stale value when empty)
//   full, empty   occupancy flags
module instruction_fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner feeding l1i and queueing fetched words for decode
//   clock, reset      posedge clock, async active-high reset
//   l1i_address       current PC presented to l1i (held stable during a miss)
//   l1i_output_data   word returned by l1i
//   l1i_hit/ready     l1i has the word / l1i has no refill in flight
//   redirect_valid/pc one-cycle PC redirect from execute (low two bits dropped)
//   instr_valid/ready/instr/instr_pc  head of fetch buffer, valid/ready handshake
//   miss_cycles       saturating count of cycles spent waiting on a miss
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] l1i_address,
    input  logic [XLEN-1:0] l1i_output_data,
    input  logic            l1i_hit,
    input  logic            l1i_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] miss_cycles
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, pc_next, pending_pc, pending_pc_next;
    logic            pending, pending_next;
    logic            push, pop, full, empty, can_push;

    assign l1i_address = pc;
    assign instr_valid = ~empty;
    assign pop         = instr_valid & instr_ready;
    assign can_push    = ~full | pop;

    instruction_fetch_buffer #(
        .WIDTH(2 * XLEN),
        .DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .din  ({pc, l1i_output_data}),
        .dout ({instr_pc, instr}),
        .full (full),
        .empty(empty)
    );

    // During a miss the address must not move, so a redirect is parked in
    // pending_pc and only takes effect once l1i reports the refill is over;
    // the refill word itself belongs to the stale path and is dropped.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pending_next    = pending;
        pending_pc_next = pending_pc;
        push            = 1'b0;
        if (state == FETCH_RUN) begin
            if (redirect_valid) begin
                pc_next = align_pc(redirect_pc);
            end else if (l1i_hit && l1i_ready) begin
                push    = can_push;
                pc_next = can_push ? pc + INSTR_BYTES : pc;
            end else if (!l1i_hit) begin
                state_next = FETCH_MISS;
            end
        end else if (l1i_ready && (pending || redirect_valid)) begin
            pc_next      = redirect_valid ? align_pc(redirect_pc) : pending_pc;
            pending_next = 1'b0;
            state_next   = FETCH_RUN;
        end else if (l1i_ready && l1i_hit && can_push) begin
            push       = 1'b1;
            pc_next    = pc + INSTR_BYTES;
            state_next = FETCH_RUN;
        end else if (redirect_valid) begin
            pending_next    = 1'b1;
            pending_pc_next = align_pc(redirect_pc);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            pending_pc  <= '0;
            miss_cycles <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pending     <= pending_next;
            pending_pc  <= pending_pc_next;
            miss_cycles <= (state == FETCH_MISS && miss_cycles != '1) ? miss_cycles + 1'b1 : miss_cycles;
        end
    end

endmodule
